// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the matmul tile accumulator.
//   state_e : controller FSM states (IDLE, LOAD, COMPUTE, DRAIN)
//   acc_w() : accumulator/result width for a given operand precision (4*P)
// The operand/accumulator array typedefs depend on the M/N/K/P parameters
// of the instantiating module, so they are declared there in terms of acc_w().
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  function automatic int acc_w(input int p);
    return 4 * p;
  endfunction

endpackage

// File: rtl/matmul_tile_perf_counters.sv
// matmul_tile_perf_counters: two saturating 32-bit event counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (job start), has priority over counting
//   busy_i     : cycle-count enable
//   stall_i    : stall-count enable
//   cycles_o   : number of busy cycles since the last clear
//   stalls_o   : number of stall cycles since the last clear
module matmul_tile_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        busy_i,
  input  logic        stall_i,
  output logic [31:0] cycles_o,
  output logic [31:0] stalls_o
);

  logic [31:0] cycles_q, cycles_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    cycles_d = cycles_q;
    stalls_d = stalls_q;
    if (clr_i) begin
      cycles_d = '0;
      stalls_d = '0;
    end else begin
      // Hold at all-ones instead of wrapping.
      if (busy_i && !(&cycles_q)) cycles_d = cycles_q + 32'd1;
      if (stall_i && !(&stalls_q)) stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
      stalls_q <= '0;
    end else begin
      cycles_q <= cycles_d;
      stalls_q <= stalls_d;
    end
  end

  assign cycles_o = cycles_q;
  assign stalls_o = stalls_q;

endmodule

// File: rtl/matmul_tile_accumulator.sv
// matmul_tile_accumulator: sequential controller wrapped around an external,
// combinational matrix_multiplication_accumulation block (D = C + A*B).
// A job of cfg_num_tiles K-chunks is accumulated by feeding D back as C, so
// the result has an effective inner dimension of K*num_tiles.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready        job start handshake; cfg_num_tiles, cfg_halved,
//                              cfg_bias (initial accumulator) sampled on it
//   in_valid/in_ready          tile handshake; in_a (MxK), in_b (KxN)
//   mm_a, mm_b, mm_c, mm_halved drive the matmul A, B, C, halvedPrecision
//   mm_d                       matmul D result
//   out_valid/out_ready        result handshake; out_d is the accumulator
//   busy                       high whenever the FSM is not IDLE
// Optional feature (macro MATMUL_TILE_PERF_CNT_EN): adds perf_cycles and
// perf_stalls saturating counters, cleared at each job start.
module matmul_tile_accumulator
  import matmul_pkg::*;
#(
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K      = 2,
  parameter int P      = 8,
  parameter int TILE_W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [TILE_W-1:0]                    cfg_num_tiles,
  input  logic                                 cfg_halved,
  input  logic [M-1:0][N-1:0][acc_w(P)-1:0]    cfg_bias,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [M-1:0][K-1:0][P-1:0]           in_a,
  input  logic [K-1:0][N-1:0][P-1:0]           in_b,
  output logic [M-1:0][K-1:0][P-1:0]           mm_a,
  output logic [K-1:0][N-1:0][P-1:0]           mm_b,
  output logic [M-1:0][N-1:0][acc_w(P)-1:0]    mm_c,
  output logic                                 mm_halved,
  input  logic [M-1:0][N-1:0][acc_w(P)-1:0]    mm_d,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [M-1:0][N-1:0][acc_w(P)-1:0]    out_d,
  output logic                                 busy
`ifdef MATMUL_TILE_PERF_CNT_EN
  ,
  output logic [31:0]                          perf_cycles,
  output logic [31:0]                          perf_stalls
`endif
);

  localparam int ACC_W = acc_w(P);

  typedef logic [M-1:0][K-1:0][P-1:0]     a_tile_t;
  typedef logic [K-1:0][N-1:0][P-1:0]     b_tile_t;
  typedef logic [M-1:0][N-1:0][ACC_W-1:0] acc_t;

  state_e            state_q, state_d;
  a_tile_t           a_q, a_d;
  b_tile_t           b_q, b_d;
  acc_t              acc_q, acc_d;
  logic [TILE_W-1:0] rem_q, rem_d;
  logic              halved_q, halved_d;

  logic cfg_hs, in_hs, out_hs;

  // Handshake readiness is a pure state decode.
  assign cfg_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q != ST_IDLE);

  assign cfg_hs = cfg_valid & cfg_ready;
  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    halved_d = halved_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_hs) begin
          acc_d    = cfg_bias;
          rem_d    = cfg_num_tiles;
          halved_d = cfg_halved;
          state_d  = (cfg_num_tiles != '0) ? ST_LOAD : ST_DRAIN;
        end
      end
      ST_LOAD: begin
        if (in_hs) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        // The matmul is combinational: D already reflects C + A*B here.
        acc_d   = mm_d;
        rem_d   = rem_q - TILE_W'(1);
        state_d = (rem_q == TILE_W'(1)) ? ST_DRAIN : ST_LOAD;
      end
      ST_DRAIN: begin
        if (out_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      halved_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      halved_q <= halved_d;
    end
  end

  assign mm_a      = a_q;
  assign mm_b      = b_q;
  assign mm_c      = acc_q;
  assign mm_halved = halved_q;
  assign out_d     = acc_q;

`ifdef MATMUL_TILE_PERF_CNT_EN
  // A stall is a LOAD cycle without a tile or a DRAIN cycle without a taker.
  matmul_tile_perf_counters u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (cfg_hs),
    .busy_i   (busy),
    .stall_i  ((in_ready & ~in_valid) | (out_valid & ~out_ready)),
    .cycles_o (perf_cycles),
    .stalls_o (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_matmul_tile_accumulator.sv
// tb_matmul_tile_accumulator: directed bench for matmul_tile_accumulator with
// M=N=K=2, P=8. A behavioural D = C + A*B model stands in for the matmul.
module tb_matmul_tile_accumulator;

  typedef logic [1:0][1:0][7:0]  op_t;
  typedef logic [1:0][1:0][31:0] acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_num_tiles = '0;
  logic        cfg_halved = 1'b0;
  acc_t        cfg_bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  op_t         in_a = '0;
  op_t         in_b = '0;
  op_t         mm_a;
  op_t         mm_b;
  acc_t        mm_c;
  logic        mm_halved;
  acc_t        mm_d;
  logic        out_valid;
  logic        out_ready = 1'b0;
  acc_t        out_d;
  logic        busy;
`ifdef MATMUL_TILE_PERF_CNT_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stalls;
`endif

  int n_vec = 0;
  int n_err = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  matmul_tile_accumulator #(
    .M(2), .N(2), .K(2), .P(8), .TILE_W(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_num_tiles (cfg_num_tiles),
    .cfg_halved    (cfg_halved),
    .cfg_bias      (cfg_bias),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .mm_a          (mm_a),
    .mm_b          (mm_b),
    .mm_c          (mm_c),
    .mm_halved     (mm_halved),
    .mm_d          (mm_d),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_d         (out_d),
    .busy          (busy)
`ifdef MATMUL_TILE_PERF_CNT_EN
    ,
    .perf_cycles   (perf_cycles),
    .perf_stalls   (perf_stalls)
`endif
  );

  function automatic logic signed [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  // Stand-in for matrix_multiplication_accumulation: D = C + A*B, 32-bit wrap.
  always_comb begin
    mm_d = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        mm_d[i][j] = mm_c[i][j];
        for (int k = 0; k < 2; k++) begin
          mm_d[i][j] = mm_d[i][j] + sx8(mm_a[i][k]) * sx8(mm_b[k][j]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) hs_cnt <= hs_cnt + 1;
  end

  function automatic op_t op2(input int e00, input int e01, input int e10, input int e11);
    op_t r;
    r[0][0] = 8'(e00);
    r[0][1] = 8'(e01);
    r[1][0] = 8'(e10);
    r[1][1] = 8'(e11);
    return r;
  endfunction

  function automatic acc_t acc2(input int e00, input int e01, input int e10, input int e11);
    acc_t r;
    r[0][0] = 32'(e00);
    r[0][1] = 32'(e01);
    r[1][0] = 32'(e10);
    r[1][1] = 32'(e11);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int nt, input acc_t bias, input logic hv);
    cfg_num_tiles = 8'(nt);
    cfg_bias      = bias;
    cfg_halved    = hv;
    cfg_valid     = 1'b1;
    tick();
    cfg_valid     = 1'b0;
  endtask

  // Returns #1 after the tile handshake edge.
  task automatic send_tile(input op_t a, input op_t b);
    int t;
    t = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    else tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    check("out_valid_wait", out_valid, 1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    acc_t held;
    int   hs_base;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_d", out_d, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_mm_halved", mm_halved, 0);

    // Single tile with latency check
    start_job(1, acc2(0, 0, 0, 0), 1'b0);
    check("single_busy", busy, 1);
    check("single_in_ready", in_ready, 1);
    send_tile(op2(1, 2, 3, 4), op2(5, 6, 7, 8));
    check("single_compute_in_ready", in_ready, 0);
    check("single_out_valid_early", out_valid, 0);
    tick();
    check("single_out_valid", out_valid, 1);
    check("single_out_d", out_d, acc2(19, 22, 43, 50));
    take_out();
    check("single_cfg_ready_after", cfg_ready, 1);
    check("single_busy_after", busy, 0);

    // Three tiles, identity times all-ones, bias 10
    hs_base = hs_cnt;
    start_job(3, acc2(10, 10, 10, 10), 1'b0);
    for (int t = 0; t < 3; t++) begin
      send_tile(op2(1, 0, 0, 1), op2(1, 1, 1, 1));
      check("three_compute_in_ready", in_ready, 0);
    end
    wait_out();
    check("three_out_d", out_d, acc2(13, 13, 13, 13));
    check("three_hs_count", hs_cnt - hs_base, 3);
    take_out();

    // Zero tiles: bias passes straight through, stray tiles ignored
    hs_base  = hs_cnt;
    in_a     = op2(9, 9, 9, 9);
    in_b     = op2(9, 9, 9, 9);
    in_valid = 1'b1;
    start_job(0, acc2(-5, 7, 0, 1), 1'b1);
    check("zero_out_valid", out_valid, 1);
    check("zero_out_d", out_d, acc2(-5, 7, 0, 1));
    check("zero_in_ready", in_ready, 0);
    check("zero_mm_halved", mm_halved, 1);
    take_out();
    in_valid = 1'b0;
    check("zero_hs_count", hs_cnt - hs_base, 0);
    check("zero_cfg_ready", cfg_ready, 1);

    // Backpressure in DRAIN
    start_job(1, acc2(0, 0, 0, 0), 1'b0);
    send_tile(op2(1, 2, 3, 4), op2(5, 6, 7, 8));
    tick();
    held = out_d;
    check("bp_out_d", held, acc2(19, 22, 43, 50));
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_d_stable", out_d, held);
      check("bp_cfg_ready", cfg_ready, 0);
      tick();
    end
`ifdef MATMUL_TILE_PERF_CNT_EN
    check("bp_perf_stalls_min", perf_stalls >= 32'd5, 1);
    check("bp_perf_stalls", perf_stalls, 5);
`endif
    take_out();
    check("bp_cfg_ready_after", cfg_ready, 1);
    check("bp_busy_after", busy, 0);
`ifdef MATMUL_TILE_PERF_CNT_EN
    check("bp_perf_cycles", perf_cycles, 8);
`endif

    // Wrap-around of the 32-bit accumulator
    start_job(1, acc2(2147483647, 0, 0, 0), 1'b0);
    send_tile(op2(1, 0, 0, 1), op2(1, 0, 0, 1));
    wait_out();
    check("wrap_out_d", out_d, {32'd1, 32'd0, 32'd0, 32'h8000_0000});
    take_out();

    // Asynchronous reset during COMPUTE discards the job
    start_job(2, acc2(100, 100, 100, 100), 1'b0);
    send_tile(op2(3, 3, 3, 3), op2(4, 4, 4, 4));
    check("abort_in_compute", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_cfg_ready", cfg_ready, 1);
    check("abort_acc", out_d, 0);
    check("abort_mm_a", mm_a, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("abort_out_valid", out_valid, 0);
    check("abort_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_tile_accumulator.md
# matmul_tile_accumulator

- Sequential controller that sits directly around `matrix_multiplication_accumulation`.
- Accepts a job of `num_tiles` K-chunks of A/B operand tiles over a valid/ready stream.
- Drives the matmul's A/B/C inputs from registers and feeds the matmul's D output back as C for the next chunk.
- Presents the final M×N accumulated result on a valid/ready output, giving an effective inner dimension of K·num_tiles.

## Interface
Parameters:
- `M`, default 2: rows of A, C and D.
- `N`, default 2: columns of B, C and D.
- `K`, default 2: inner dimension of one tile.
- `P`, default 8: operand precision in bits. Accumulator and result width is 4·P.
- `TILE_W`, default 8: width of the tile-count field.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cfg_valid` in 1: job start request.
- `cfg_ready` out 1: the block can accept a job.
- `cfg_num_tiles` in TILE_W: number of K-chunks in the job.
- `cfg_halved` in 1: halvedPrecision mode for the job.
- `cfg_bias` in [M][N] signed 4P: initial accumulator value.
- `in_valid` in 1: tile valid.
- `in_ready` out 1: tile accepted when high together with `in_valid`.
- `in_a` in [M][K] signed P: A tile.
- `in_b` in [K][N] signed P: B tile.
- `mm_a` out [M][K] P: drives matmul `A`.
- `mm_b` out [K][N] P: drives matmul `B`.
- `mm_c` out [M][N] 4P: drives matmul `C`.
- `mm_halved` out 1: drives matmul `halvedPrecision`.
- `mm_d` in [M][N] 4P: matmul `D` result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when high together with `out_valid`.
- `out_d` out [M][N] 4P: accumulated result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE:
  - `cfg_ready`=1.
  - On a cfg handshake: acc←`cfg_bias`, remaining←`cfg_num_tiles`, halved←`cfg_halved`.
  - Next state is LOAD if `cfg_num_tiles`≠0, otherwise DRAIN.
- LOAD:
  - `in_ready`=1.
  - On a tile handshake: operand registers←`in_a`/`in_b`, next state COMPUTE.
- COMPUTE:
  - acc←`mm_d` (the matmul is combinational).
  - remaining decrements.
  - Next state is DRAIN if remaining was 1, otherwise LOAD.
- DRAIN:
  - `out_valid`=1.
  - On an out handshake, return to IDLE.
- `mm_c` is always acc. `mm_a` and `mm_b` are always the operand registers. `mm_halved` is the latched halved bit, constant for the whole job.
- `out_d` is always acc. It is stable while `out_valid`=1 and `out_ready`=0.
- Arithmetic: 4P-bit two's complement with wrap-around, no saturation. The block adds no arithmetic of its own; the accumulation comes from the matmul C+A·B.
- `in_valid` is ignored outside LOAD. `cfg_valid` is ignored outside IDLE.
- An asserted `rst_n` mid-job aborts the job immediately. All state returns to reset values and the partial result is discarded.

## Timing
- Reset values:
  - State IDLE, `cfg_ready`=1.
  - `in_ready`, `out_valid`, `busy`, `mm_halved` = 0.
  - acc, operand registers, `out_d`, `mm_a`, `mm_b`, `mm_c` = 0.
  - remaining = 0.
- `busy` rises the cycle after the cfg handshake.
- Each tile costs 2 cycles (LOAD, then COMPUTE). Throughput is one tile per 2 cycles when `in_valid` is held high.
- `out_valid` rises 2 cycles after the last tile handshake edge.
- With `num_tiles`=0, `out_valid` rises 1 cycle after the cfg handshake and `out_d`=`cfg_bias`.
- `cfg_ready` rises the cycle after the out handshake; back-to-back jobs therefore have 1 idle cycle between them.
- `in_ready` and `cfg_ready` are pure state decodes with no combinational dependence on `in_valid`, `cfg_valid` or `out_ready`.

## Configuration
- Macro: `MATMUL_TILE_PERF_CNT_EN`.
- Defined:
  - Adds outputs `perf_cycles` (32 bits) and `perf_stalls` (32 bits).
  - `perf_cycles` counts cycles with `busy`=1.
  - `perf_stalls` counts LOAD cycles with `in_valid`=0 plus DRAIN cycles with `out_ready`=0.
  - Both counters clear on a cfg handshake and saturate at all-ones.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `matmul_pkg`:
  - FSM state enum.
  - `ACC_W` = 4·P helper.
  - Operand and accumulator array typedefs, parameterised via the module.
- The matmul is instantiated by the parent, not inside this block.
- One sub-module: `matmul_tile_perf_counters`, instantiated only under `MATMUL_TILE_PERF_CNT_EN`.

## Test plan
All scenarios use M=N=K=2, P=8.
- Reset: after reset deassertion, `cfg_ready`=1, `busy`=0, `out_valid`=0 and `out_d`=0. Asserting `rst_n` during COMPUTE returns to IDLE with acc=0.
- Single tile: bias 0, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → `out_d`=[[19,22],[43,50]], with `out_valid` 2 cycles after the tile handshake.
- Three tiles: bias all 10; each tile A=I, B=all ones → `out_d` all 13. Exactly 3 `in` handshakes occur and `in_ready`=0 in COMPUTE.
- Zero tiles: `cfg_num_tiles`=0, bias [[−5,7],[0,1]] → `out_d` equals the bias 1 cycle after cfg, with no `in_ready` pulse.
- Backpressure: `out_ready` held low for 5 cycles in DRAIN → `out_d` and `out_valid` stay stable and `cfg_ready`=0. On the handshake, the block returns to IDLE the next cycle. With the macro defined, `perf_stalls`≥5.
- Wrap-around: bias[0][0]=2147483647, A=I, B=I → `out_d`[0][0]=−2147483648; other entries are 0 or 1 per I.
